// File: rtl/clkgen_prog_divider.sv
// ---------------------------------------------------------------------------
// clkgen_prog_divider
//
// Purpose:
//   Runtime-programmable clock divider that generates the SCL timebase for the
//   I2C master. It produces a registered 50 % duty divided clock plus
//   single-cycle phase strobes marking the rising edge, the falling edge, the
//   middle of the high phase (sample point) and the middle of the low phase
//   (data-change point). The divider can be started and stopped cleanly (it
//   always parks at IDLE_LEVEL without truncating the idle-level phase). The
//   divisor can be reloaded at run time without glitches: a new value only
//   takes effect on a half-period boundary.
//
// Parameters:
//   CNT_W        width of the half-period counter and divisor
//   DEFAULT_HALF divisor after reset; half-period = DEFAULT_HALF+1 cycles
//   IDLE_LEVEL   clk_out level while idle/stopped
//
// Ports:
//   clk_50MHz    in   1      system clock, all logic on rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   en           in   1      1 = run divider, 0 = stop at IDLE_LEVEL
//   load         in   1      1-cycle strobe: capture half_period
//   half_period  in   CNT_W  new divisor N; half-period = N+1 cycles
//   clk_out      out  1      divided clock, registered
//   tick_rise    out  1      pulse in the cycle clk_out becomes 1
//   tick_fall    out  1      pulse in the cycle clk_out becomes 0
//   tick_mid_hi  out  1      pulse at the middle of the high phase
//   tick_mid_lo  out  1      pulse at the middle of the low phase
//   active       out  1      1 while running or stopping
// ---------------------------------------------------------------------------
module clkgen_prog_divider #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 124,
  parameter bit IDLE_LEVEL   = 1'b1
) (
  input  logic             clk_50MHz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] half_period,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             tick_mid_hi,
  output logic             tick_mid_lo,
  output logic             active
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  // Registered state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_clk_out;
  logic             r_tick_rise;
  logic             r_tick_fall;
  logic             r_tick_mid_hi;
  logic             r_tick_mid_lo;
  logic             r_active;

  // Next-state values
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             w_pend_vld_nxt;
  logic             w_clk_nxt;
  logic             w_toggle;
  logic             w_apply;
  logic             w_boundary;
  logic             w_running_nxt;
  logic             w_mid_nxt;

  assign w_boundary = (r_cnt == r_div);

  // Next-state / datapath logic.
  // Every output is registered from the value it will hold next cycle, so the
  // edge ticks line up exactly with the clk_out change and the mid ticks line
  // up with the cycle in which the counter shows the mid-point value.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_div_nxt      = r_div;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    w_clk_nxt      = r_clk_out;
    w_toggle       = 1'b0;
    w_apply        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_clk_nxt = IDLE_LEVEL;
        // No phase is in progress, so a pending divisor can go in at once.
        w_apply   = r_pend_vld;
        if (en) begin
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (w_boundary) begin
          w_cnt_nxt = '0;
          w_toggle  = 1'b1;
          w_apply   = r_pend_vld;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (!en) begin
          w_state_nxt = S_STOPPING;
        end
      end

      S_STOPPING: begin
        if (w_boundary) begin
          w_cnt_nxt = '0;
          w_apply   = r_pend_vld;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (en) begin
          // Re-enabled before the stop completed: carry on as if never stopped.
          w_state_nxt = S_RUN;
          w_toggle    = w_boundary;
        end else if (w_boundary) begin
          // Only toggle if we are not already at the idle level, so the
          // idle-level phase is never cut short.
          w_toggle    = (r_clk_out != IDLE_LEVEL);
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_clk_nxt   = IDLE_LEVEL;
      end
    endcase

    if (w_toggle) begin
      w_clk_nxt = ~r_clk_out;
    end

    if (w_apply) begin
      w_div_nxt      = r_pend;
      w_pend_vld_nxt = 1'b0;
    end

    // A fresh load always wins over the pending slot, including in the cycle
    // the previous pending value is being applied.
    if (load) begin
      w_pend_nxt     = half_period;
      w_pend_vld_nxt = 1'b1;
    end
  end

  assign w_running_nxt = (w_state_nxt != S_IDLE);
  assign w_mid_nxt     = w_running_nxt && (w_cnt_nxt == (w_div_nxt >> 1));

  // State and output registers.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_div         <= CNT_W'(DEFAULT_HALF);
      r_pend        <= '0;
      r_pend_vld    <= 1'b0;
      r_clk_out     <= IDLE_LEVEL;
      r_tick_rise   <= 1'b0;
      r_tick_fall   <= 1'b0;
      r_tick_mid_hi <= 1'b0;
      r_tick_mid_lo <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_div         <= w_div_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_vld    <= w_pend_vld_nxt;
      r_clk_out     <= w_clk_nxt;
      r_tick_rise   <= w_toggle && !r_clk_out;
      r_tick_fall   <= w_toggle && r_clk_out;
      r_tick_mid_hi <= w_mid_nxt && w_clk_nxt;
      r_tick_mid_lo <= w_mid_nxt && !w_clk_nxt;
      r_active      <= w_running_nxt;
    end
  end

  assign clk_out     = r_clk_out;
  assign tick_rise   = r_tick_rise;
  assign tick_fall   = r_tick_fall;
  assign tick_mid_hi = r_tick_mid_hi;
  assign tick_mid_lo = r_tick_mid_lo;
  assign active      = r_active;

endmodule

// File: tb/tb_clkgen_prog_divider.sv
// ---------------------------------------------------------------------------
// tb_clkgen_prog_divider
//
// Purpose:
//   Directed, self-checking bench for clkgen_prog_divider. Each scenario task
//   drives its own stimulus and compares the observed timing against
//   hand-computed cycle counts. Outputs are sampled on the falling clock edge;
//   inputs are changed right after sampling.
// ---------------------------------------------------------------------------
module tb_clkgen_prog_divider;

  localparam int CNT_W = 16;

  logic             clk_50MHz;
  logic             rst_n;
  logic             en;
  logic             load;
  logic [CNT_W-1:0] half_period;
  logic             clk_out;
  logic             tick_rise;
  logic             tick_fall;
  logic             tick_mid_hi;
  logic             tick_mid_lo;
  logic             active;

  int checks;
  int errors;

  clkgen_prog_divider #(
    .CNT_W       (CNT_W),
    .DEFAULT_HALF(124),
    .IDLE_LEVEL  (1'b1)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .half_period(half_period),
    .clk_out    (clk_out),
    .tick_rise  (tick_rise),
    .tick_fall  (tick_fall),
    .tick_mid_hi(tick_mid_hi),
    .tick_mid_lo(tick_mid_lo),
    .active     (active)
  );

  // 50 MHz system clock
  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  // Waits on falling edges until the selected output is seen, returning the
  // number of edges waited, or -1 when the budget runs out.
  // which: 0 rise, 1 fall, 2 mid_hi, 3 mid_lo, 4 any edge tick
  task automatic wait_evt(input int which, input int maxc, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < maxc) begin
      @(negedge clk_50MHz);
      n++;
      case (which)
        0:       hit = tick_rise;
        1:       hit = tick_fall;
        2:       hit = tick_mid_hi;
        3:       hit = tick_mid_lo;
        default: hit = tick_rise | tick_fall;
      endcase
    end
    if (!hit) n = -1;
  endtask

  // Reset values while held and after a mid-run asynchronous reset
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; half_period = '0;
    #25;
    checks++;
    if ({clk_out, tick_rise, tick_fall, tick_mid_hi, tick_mid_lo, active} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %b expected 100000",
               {clk_out, tick_rise, tick_fall, tick_mid_hi, tick_mid_lo, active});
    end
    @(negedge clk_50MHz) rst_n = 1'b1;
    repeat (5) @(negedge clk_50MHz);
    checks++;
    if ({clk_out, tick_rise, tick_fall, tick_mid_hi, tick_mid_lo, active} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: got %b expected 100000",
               {clk_out, tick_rise, tick_fall, tick_mid_hi, tick_mid_lo, active});
    end
    en = 1'b1;
    repeat (200) @(negedge clk_50MHz);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_prerun_active: got %b expected 1", active);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick_rise, tick_fall, tick_mid_hi, tick_mid_lo, active} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_async: got %b expected 100000",
               {clk_out, tick_rise, tick_fall, tick_mid_hi, tick_mid_lo, active});
    end
    @(negedge clk_50MHz);
    rst_n = 1'b1;
    en = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    checks++;
    if ({clk_out, tick_rise, tick_fall, tick_mid_hi, tick_mid_lo, active} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_hold_after: got %b expected 100000",
               {clk_out, tick_rise, tick_fall, tick_mid_hi, tick_mid_lo, active});
    end
  endtask

  // Default divisor: 125-cycle phases, one rise per 250-cycle period
  task automatic test_default();
    int n;
    int rises;
    en = 1'b1;
    @(negedge clk_50MHz);
    checks++;
    if ({active, clk_out} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL default_entry: got %b expected 11", {active, clk_out});
    end
    wait_evt(1, 300, n);
    checks++;
    if (n !== 125) begin
      errors++;
      $display("[TB] FAIL default_first_fall: got %0d expected 125", n);
    end
    wait_evt(0, 300, n);
    checks++;
    if (n !== 125) begin
      errors++;
      $display("[TB] FAIL default_low_len: got %0d expected 125", n);
    end
    wait_evt(1, 300, n);
    checks++;
    if (n !== 125) begin
      errors++;
      $display("[TB] FAIL default_high_len: got %0d expected 125", n);
    end
    rises = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk_50MHz);
      if (tick_rise) rises++;
    end
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("[TB] FAIL default_rises_per_period: got %0d expected 1", rises);
    end
  endtask

  // Mid ticks 62 cycles into each phase at div=124
  task automatic test_mid_ticks();
    int n;
    wait_evt(0, 300, n);
    wait_evt(2, 300, n);
    checks++;
    if (n !== 62 || clk_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_hi: got %0d/%b expected 62/1", n, clk_out);
    end
    wait_evt(1, 300, n);
    checks++;
    if (n !== 63) begin
      errors++;
      $display("[TB] FAIL mid_hi_to_fall: got %0d expected 63", n);
    end
    wait_evt(3, 300, n);
    checks++;
    if (n !== 62 || clk_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_lo: got %0d/%b expected 62/0", n, clk_out);
    end
  endtask

  // Reload mid-phase: current phase keeps 125 cycles, then 5-cycle phases
  task automatic test_reload();
    int n;
    wait_evt(0, 300, n);
    wait_evt(1, 300, n);
    repeat (50) @(negedge clk_50MHz);
    load = 1'b1;
    half_period = 16'd4;
    @(negedge clk_50MHz);
    load = 1'b0;
    wait_evt(4, 300, n);
    checks++;
    if (n !== 74 || tick_rise !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reload_current_phase: got %0d/%b expected 74/1", n, tick_rise);
    end
    wait_evt(4, 300, n);
    checks++;
    if (n !== 5 || tick_fall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reload_new_high: got %0d/%b expected 5/1", n, tick_fall);
    end
    wait_evt(4, 300, n);
    checks++;
    if (n !== 5 || tick_rise !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reload_new_low: got %0d/%b expected 5/1", n, tick_rise);
    end
  endtask

  // Stop while low (finishes with a rise) and while high (no toggle)
  task automatic test_stop();
    int n;
    int ticks;
    int firstIdle;
    wait_evt(1, 50, n);
    en = 1'b0;
    wait_evt(4, 50, n);
    checks++;
    if (n !== 5 || {tick_rise, clk_out, active} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL stop_low: got %0d/%b expected 5/110", n, {tick_rise, clk_out, active});
    end
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50MHz);
      ticks += int'(tick_rise) + int'(tick_fall) + int'(tick_mid_hi) + int'(tick_mid_lo);
    end
    checks++;
    if (ticks !== 0 || {clk_out, active} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL stop_idle_quiet: got %0d/%b expected 0/10", ticks, {clk_out, active});
    end
    en = 1'b1;
    @(negedge clk_50MHz);
    wait_evt(1, 50, n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("[TB] FAIL restart_first_fall: got %0d expected 5", n);
    end
    wait_evt(0, 50, n);
    en = 1'b0;
    ticks = 0;
    firstIdle = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk_50MHz);
      ticks += int'(tick_rise) + int'(tick_fall);
      if (!active && firstIdle < 0) firstIdle = i;
    end
    checks++;
    if (firstIdle !== 5 || ticks !== 0 || clk_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stop_high: got idle@%0d ticks %0d clk %b expected idle@5 ticks 0 clk 1",
               firstIdle, ticks, clk_out);
    end
  endtask

  // div=0: toggles every cycle, each cycle carries an edge and a mid tick
  task automatic test_div_zero();
    logic [4:0] expv;
    half_period = '0;
    load = 1'b1;
    @(negedge clk_50MHz);
    load = 1'b0;
    repeat (2) @(negedge clk_50MHz);
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_50MHz);
      if (k == 1)          expv = 5'b10010;
      else if (k % 2 == 1) expv = 5'b11010;
      else                 expv = 5'b00101;
      checks++;
      if ({clk_out, tick_rise, tick_fall, tick_mid_hi, tick_mid_lo} !== expv) begin
        errors++;
        $display("[TB] FAIL div0_cycle%0d: got %b expected %b", k,
                 {clk_out, tick_rise, tick_fall, tick_mid_hi, tick_mid_lo}, expv);
      end
    end
    en = 1'b0;
    repeat (4) @(negedge clk_50MHz);
    checks++;
    if ({clk_out, active} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL div0_stop: got %b expected 10", {clk_out, active});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_default();
    test_mid_ticks();
    test_reload();
    test_stop();
    test_div_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
